// File: rtl/fwd_hazard_unit.sv
// Operand forwarding (EX and ID-branch) and counter-based stall FSM for a 5-stage pipeline.
// Optional stall_cycles counter: define HAZ_STALL_CNT_EN.
module fwd_hazard_unit #(
    parameter int ADDR_W   = 5,
    parameter int NUM_SRC  = 2,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = $clog2(LOAD_LAT + 2)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_SRC*ADDR_W-1:0]   id_src,
    input  logic [NUM_SRC-1:0]          id_src_vld,
    input  logic                        id_is_branch,
    input  logic [NUM_SRC*ADDR_W-1:0]   ex_src,
    input  logic [ADDR_W-1:0]           ex_rd,
    input  logic                        ex_regwrite,
    input  logic                        ex_memread,
    input  logic [ADDR_W-1:0]           mem_rd,
    input  logic                        mem_regwrite,
    input  logic                        mem_memread,
    input  logic [ADDR_W-1:0]           wb_rd,
    input  logic                        wb_regwrite,
    input  logic                        mem_stall,
    input  logic                        flush,
    output logic [2*NUM_SRC-1:0]        fwd_ex,
    output logic [2*NUM_SRC-1:0]        fwd_id,
    output logic                        stall,
    output logic [1:0]                  stall_cause,
    output logic                        dbg_state
`ifdef HAZ_STALL_CNT_EN
    ,
    output logic [31:0]                 stall_cycles
`endif
);

    typedef enum logic {IDLE = 1'b0, STALL = 1'b1} state_t;

    localparam logic [CNT_W-1:0] NEED_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] NEED_TWO     = CNT_W'(2);
    localparam logic [CNT_W-1:0] NEED_LOAD    = CNT_W'(LOAD_LAT);
    localparam logic [CNT_W-1:0] NEED_BR_LOAD = CNT_W'(LOAD_LAT + 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  need;
    logic [1:0]        cause;
    logic [CNT_W-1:0]  src_need;
    logic [1:0]        src_cause;
    logic [ADDR_W-1:0] ex_s;
    logic [ADDR_W-1:0] id_s;

    always_comb begin
        fwd_ex    = '0;
        fwd_id    = '0;
        need      = '0;
        cause     = 2'b00;
        src_need  = '0;
        src_cause = 2'b00;
        ex_s      = '0;
        id_s      = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            ex_s = ex_src[i*ADDR_W +: ADDR_W];
            id_s = id_src[i*ADDR_W +: ADDR_W];

            if (mem_regwrite && mem_rd != '0 && mem_rd == ex_s)
                fwd_ex[2*i +: 2] = 2'b01;
            else if (wb_regwrite && wb_rd != '0 && wb_rd == ex_s)
                fwd_ex[2*i +: 2] = 2'b10;

            // A load still in MEM has no data yet, so it cannot feed the ID compare.
            if (id_is_branch && id_src_vld[i]) begin
                if (mem_regwrite && !mem_memread && mem_rd != '0 && mem_rd == id_s)
                    fwd_id[2*i +: 2] = 2'b01;
                else if (wb_regwrite && wb_rd != '0 && wb_rd == id_s)
                    fwd_id[2*i +: 2] = 2'b10;
            end

            src_need  = '0;
            src_cause = 2'b00;
            if (id_src_vld[i] && id_s != '0) begin
                if (id_is_branch && ex_memread && id_s == ex_rd) begin
                    src_need  = NEED_BR_LOAD;
                    src_cause = 2'b11;
                end else if (id_is_branch && ex_regwrite && id_s == ex_rd) begin
                    src_need  = NEED_ONE;
                    src_cause = 2'b10;
                end else if (id_is_branch && mem_memread && id_s == mem_rd) begin
                    src_need  = NEED_ONE;
                    src_cause = 2'b11;
                end else if (!id_is_branch && ex_memread && id_s == ex_rd) begin
                    src_need  = NEED_LOAD;
                    src_cause = 2'b01;
                end
            end

            // Longest hazard wins; on equal length a load cause is reported.
            if (src_need > need) begin
                need  = src_need;
                cause = src_cause;
            end else if (src_need == need && src_need != '0 && src_cause == 2'b11) begin
                cause = src_cause;
            end
        end

        if (!rst) begin
            fwd_ex = '0;
            fwd_id = '0;
        end
    end

    always_comb begin
        if (!rst || flush)
            stall = 1'b0;
        else if (state == STALL)
            stall = 1'b1;
        else
            stall = (need != '0);
    end

    assign dbg_state = (state == STALL);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            stall_cause <= 2'b00;
        end else if (flush) begin
            state       <= IDLE;
            cnt         <= '0;
            stall_cause <= 2'b00;
        end else if (!mem_stall) begin
            case (state)
                IDLE: begin
                    stall_cause <= (need != '0) ? cause : 2'b00;
                    if (need >= NEED_TWO) begin
                        state <= STALL;
                        cnt   <= need - NEED_ONE;
                    end
                end
                STALL: begin
                    if (cnt == NEED_ONE) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - NEED_ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef HAZ_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_cycles <= '0;
        else if (stall && stall_cycles != 32'hFFFF_FFFF)
            stall_cycles <= stall_cycles + 32'd1;
    end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: three instances (LOAD_LAT 1/2/3) share one stimulus.
// Forwarding is table-driven; stall sequences are hand-written per-cycle expectations.
module tb_fwd_hazard_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] id_src;
    logic [1:0] id_src_vld;
    logic       id_is_branch;
    logic [9:0] ex_src;
    logic [4:0] ex_rd;
    logic       ex_regwrite, ex_memread;
    logic [4:0] mem_rd;
    logic       mem_regwrite, mem_memread;
    logic [4:0] wb_rd;
    logic       wb_regwrite;
    logic       mem_stall, flush;

    logic [3:0] fwd_ex_1, fwd_ex_2, fwd_ex_3;
    logic [3:0] fwd_id_1, fwd_id_2, fwd_id_3;
    logic       stall_1, stall_2, stall_3;
    logic [1:0] cause_1, cause_2, cause_3;
    logic       dbg_1, dbg_2, dbg_3;
`ifdef HAZ_STALL_CNT_EN
    logic [31:0] cyc_1, cyc_2, cyc_3;
`endif

    logic [15:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [9:0] ex_src;
        logic [9:0] id_src;
        logic [1:0] id_vld;
        logic       br;
        logic [4:0] mem_rd;
        logic       mem_rw;
        logic       mem_mr;
        logic [4:0] wb_rd;
        logic       wb_rw;
        logic [3:0] exp_ex;
        logic [3:0] exp_id;
    } fvec_t;

    fvec_t vecs[12];

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no finish required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- DUTs ----------------
    fwd_hazard_unit #(.LOAD_LAT(1)) u_lat1 (
        .clk(clk), .rst(rst), .id_src(id_src), .id_src_vld(id_src_vld),
        .id_is_branch(id_is_branch), .ex_src(ex_src), .ex_rd(ex_rd),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .mem_rd(mem_rd),
        .mem_regwrite(mem_regwrite), .mem_memread(mem_memread), .wb_rd(wb_rd),
        .wb_regwrite(wb_regwrite), .mem_stall(mem_stall), .flush(flush),
        .fwd_ex(fwd_ex_1), .fwd_id(fwd_id_1), .stall(stall_1),
        .stall_cause(cause_1), .dbg_state(dbg_1)
`ifdef HAZ_STALL_CNT_EN
        , .stall_cycles(cyc_1)
`endif
    );

    fwd_hazard_unit #(.LOAD_LAT(2)) u_lat2 (
        .clk(clk), .rst(rst), .id_src(id_src), .id_src_vld(id_src_vld),
        .id_is_branch(id_is_branch), .ex_src(ex_src), .ex_rd(ex_rd),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .mem_rd(mem_rd),
        .mem_regwrite(mem_regwrite), .mem_memread(mem_memread), .wb_rd(wb_rd),
        .wb_regwrite(wb_regwrite), .mem_stall(mem_stall), .flush(flush),
        .fwd_ex(fwd_ex_2), .fwd_id(fwd_id_2), .stall(stall_2),
        .stall_cause(cause_2), .dbg_state(dbg_2)
`ifdef HAZ_STALL_CNT_EN
        , .stall_cycles(cyc_2)
`endif
    );

    fwd_hazard_unit #(.LOAD_LAT(3)) u_lat3 (
        .clk(clk), .rst(rst), .id_src(id_src), .id_src_vld(id_src_vld),
        .id_is_branch(id_is_branch), .ex_src(ex_src), .ex_rd(ex_rd),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .mem_rd(mem_rd),
        .mem_regwrite(mem_regwrite), .mem_memread(mem_memread), .wb_rd(wb_rd),
        .wb_regwrite(wb_regwrite), .mem_stall(mem_stall), .flush(flush),
        .fwd_ex(fwd_ex_3), .fwd_id(fwd_id_3), .stall(stall_3),
        .stall_cause(cause_3), .dbg_state(dbg_3)
`ifdef HAZ_STALL_CNT_EN
        , .stall_cycles(cyc_3)
`endif
    );

    // ---------------- driver / checker tasks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    endtask

    task automatic clear_inputs();
        id_src = '0; id_src_vld = '0; id_is_branch = 1'b0; ex_src = '0;
        ex_rd = '0; ex_regwrite = 1'b0; ex_memread = 1'b0;
        mem_rd = '0; mem_regwrite = 1'b0; mem_memread = 1'b0;
        wb_rd = '0; wb_regwrite = 1'b0; mem_stall = 1'b0; flush = 1'b0;
    endtask

    // One cycle: expected {stall_3,stall_2,stall_1} queued, compared at negedge.
    task automatic cyc(input logic [2:0] exp_stall, input string name);
        logic [15:0] e;
        exp_q.push_back({13'd0, exp_stall});
        @(negedge clk);
        e = exp_q.pop_front();
        check(name, {29'd0, stall_3, stall_2, stall_1}, {29'd0, e[2:0]});
        @(posedge clk);
        #1;
    endtask

    task automatic load_use_hazard();   // ID src0 reads r5, load to r5 in EX
        id_src = {5'd0, 5'd5}; id_src_vld = 2'b01; id_is_branch = 1'b0;
        ex_rd = 5'd5; ex_regwrite = 1'b1; ex_memread = 1'b1;
    endtask

    task automatic branch_load_hazard(input logic [4:0] r);  // branch src0 reads load dest in EX
        id_src = {5'd0, r}; id_src_vld = 2'b01; id_is_branch = 1'b1;
        ex_rd = r; ex_regwrite = 1'b1; ex_memread = 1'b1;
    endtask

    function automatic fvec_t mk(input logic [9:0] xs, input logic [9:0] is, input logic [1:0] v,
                                 input logic b, input logic [4:0] mrd, input logic mrw,
                                 input logic mmr, input logic [4:0] wrd, input logic wrw,
                                 input logic [3:0] eex, input logic [3:0] eid);
        fvec_t f;
        f.ex_src = xs; f.id_src = is; f.id_vld = v; f.br = b; f.mem_rd = mrd;
        f.mem_rw = mrw; f.mem_mr = mmr; f.wb_rd = wrd; f.wb_rw = wrw;
        f.exp_ex = eex; f.exp_id = eid;
        return f;
    endfunction

    // ---------------- test ----------------
    initial begin
        logic [15:0] e;
        // forwarding vectors: ex_src/id_src packed {src1, src0}
        vecs[0]  = mk({5'd0,5'd8}, 10'd0, 2'b00, 1'b0, 5'd8, 1'b1, 1'b0, 5'd8, 1'b1, 4'b0001, 4'b0000);
        vecs[1]  = mk({5'd4,5'd3}, 10'd0, 2'b00, 1'b0, 5'd3, 1'b1, 1'b0, 5'd4, 1'b1, 4'b1001, 4'b0000);
        vecs[2]  = mk({5'd4,5'd0}, 10'd0, 2'b00, 1'b0, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 4'b1000, 4'b0000);
        vecs[3]  = mk({5'd3,5'd3}, 10'd0, 2'b00, 1'b0, 5'd3, 1'b0, 1'b0, 5'd3, 1'b1, 4'b1010, 4'b0000);
        vecs[4]  = mk({5'd5,5'd5}, 10'd0, 2'b00, 1'b0, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 4'b0101, 4'b0000);
        vecs[5]  = mk({5'd0,5'd0}, 10'd0, 2'b00, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 4'b0000, 4'b0000);
        vecs[6]  = mk(10'd0, {5'd9,5'd9}, 2'b11, 1'b1, 5'd9, 1'b1, 1'b0, 5'd0, 1'b0, 4'b0000, 4'b0101);
        vecs[7]  = mk(10'd0, {5'd9,5'd9}, 2'b11, 1'b1, 5'd9, 1'b1, 1'b1, 5'd9, 1'b1, 4'b0000, 4'b1010);
        vecs[8]  = mk(10'd0, {5'd9,5'd9}, 2'b11, 1'b0, 5'd9, 1'b1, 1'b0, 5'd0, 1'b0, 4'b0000, 4'b0000);
        vecs[9]  = mk(10'd0, {5'd9,5'd9}, 2'b01, 1'b1, 5'd9, 1'b1, 1'b0, 5'd0, 1'b0, 4'b0000, 4'b0001);
        vecs[10] = mk(10'd0, {5'd6,5'd0}, 2'b11, 1'b1, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 4'b0000, 4'b1000);
        vecs[11] = mk({5'd6,5'd2}, {5'd2,5'd6}, 2'b11, 1'b1, 5'd2, 1'b1, 1'b0, 5'd6, 1'b1, 4'b1001, 4'b0110);

        // ---- reset: outputs forced low even with live hazards/matches ----
        clear_inputs();
        rst = 1'b0;
        mem_rd = 5'd8; mem_regwrite = 1'b1; ex_src = {5'd0, 5'd8};
        load_use_hazard();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_fwd_ex", {28'd0, fwd_ex_1}, 32'd0);
        check("rst_stall", {29'd0, stall_3, stall_2, stall_1}, 32'd0);
        check("rst_cause", {26'd0, cause_3, cause_2, cause_1}, 32'd0);
        check("rst_state", {29'd0, dbg_3, dbg_2, dbg_1}, 32'd0);
`ifdef HAZ_STALL_CNT_EN
        check("rst_stall_cycles", cyc_1, 32'd0);
`endif
        @(posedge clk); #1;
        clear_inputs();
        rst = 1'b1;
        cyc(3'b000, "idle_after_rst");

        // ---- hazards of 1, 2, 2 cycles on LOAD_LAT=1 ----
        id_src = {5'd0, 5'd2}; id_src_vld = 2'b01; id_is_branch = 1'b1;
        ex_rd = 5'd2; ex_regwrite = 1'b1;
        cyc(3'b111, "br_alu_c0");
        clear_inputs();
        check("br_alu_cause", {26'd0, cause_3, cause_2, cause_1}, 32'b101010);
        cyc(3'b000, "br_alu_c1");
        for (int k = 0; k < 2; k++) begin
            branch_load_hazard(5'd2);
            cyc(3'b111, "brld_c0");
            clear_inputs();
            cyc(3'b111, "brld_c1");
            cyc(3'b110, "brld_c2");
            cyc(3'b100, "brld_c3");
            cyc(3'b000, "brld_c4");
        end
`ifdef HAZ_STALL_CNT_EN
        check("stall_cycles_lat1", cyc_1, 32'd5);
        check("stall_cycles_lat2", cyc_2, 32'd7);
        check("stall_cycles_lat3", cyc_3, 32'd9);
`endif

        // ---- branch reading a load that is in MEM: one cycle, cause 11 ----
        id_src = {5'd4, 5'd0}; id_src_vld = 2'b10; id_is_branch = 1'b1;
        mem_rd = 5'd4; mem_memread = 1'b1; mem_regwrite = 1'b1;
        cyc(3'b111, "br_memld_c0");
        clear_inputs();
        check("br_memld_cause", {26'd0, cause_3, cause_2, cause_1}, 32'b111111);
        cyc(3'b000, "br_memld_c1");

        // ---- forwarding table ----
        for (int i = 0; i < 12; i++) begin
            ex_src = vecs[i].ex_src; id_src = vecs[i].id_src; id_src_vld = vecs[i].id_vld;
            id_is_branch = vecs[i].br; mem_rd = vecs[i].mem_rd; mem_regwrite = vecs[i].mem_rw;
            mem_memread = vecs[i].mem_mr; wb_rd = vecs[i].wb_rd; wb_regwrite = vecs[i].wb_rw;
            exp_q.push_back({8'h00, vecs[i].exp_ex, vecs[i].exp_id});
            @(negedge clk);
            e = exp_q.pop_front();
            check($sformatf("fwd_ex_v%0d", i), {28'd0, fwd_ex_1}, {28'd0, e[7:4]});
            check($sformatf("fwd_id_v%0d", i), {28'd0, fwd_id_1}, {28'd0, e[3:0]});
            check($sformatf("fwd_ex_lat3_v%0d", i), {28'd0, fwd_ex_3}, {28'd0, e[7:4]});
            @(posedge clk); #1;
        end
        clear_inputs();
        cyc(3'b000, "idle_after_table");

        // ---- load-use: stall = LOAD_LAT cycles ----
        load_use_hazard();
        cyc(3'b111, "lu_c0");
        clear_inputs();
        check("lu_cause", {26'd0, cause_3, cause_2, cause_1}, 32'b010101);
        check("lu_state", {29'd0, dbg_3, dbg_2, dbg_1}, 32'b110);
        cyc(3'b110, "lu_c1");
        cyc(3'b100, "lu_c2");
        cyc(3'b000, "lu_c3");

        // ---- branch-load: stall = LOAD_LAT+1 cycles ----
        id_src = {5'd7, 5'd0}; id_src_vld = 2'b10; id_is_branch = 1'b1;
        ex_rd = 5'd7; ex_regwrite = 1'b1; ex_memread = 1'b1;
        cyc(3'b111, "bl_c0");
        clear_inputs();
        check("bl_cause", {26'd0, cause_3, cause_2, cause_1}, 32'b111111);
        cyc(3'b111, "bl_c1");
        cyc(3'b110, "bl_c2");
        cyc(3'b100, "bl_c3");
        cyc(3'b000, "bl_c4");

        // ---- same, flushed in first stall cycle ----
        branch_load_hazard(5'd7);
        cyc(3'b111, "blf_c0");
        clear_inputs();
        flush = 1'b1;
        cyc(3'b000, "blf_flush");
        flush = 1'b0;
        check("blf_cause", {26'd0, cause_3, cause_2, cause_1}, 32'd0);
        check("blf_state", {29'd0, dbg_3, dbg_2, dbg_1}, 32'd0);
        cyc(3'b000, "blf_c2");

        // ---- load-use with mem_stall for 2 cycles mid-stall ----
        load_use_hazard();
        cyc(3'b111, "ms_c0");
        clear_inputs();
        mem_stall = 1'b1;
        cyc(3'b110, "ms_c1");
        cyc(3'b110, "ms_c2");
        check("ms_state", {29'd0, dbg_3, dbg_2, dbg_1}, 32'b110);
        mem_stall = 1'b0;
        cyc(3'b110, "ms_c3");
        cyc(3'b100, "ms_c4");
        cyc(3'b000, "ms_c5");

        // ---- load-use with reset mid-stall ----
        load_use_hazard();
        cyc(3'b111, "rs_c0");
        clear_inputs();
        check("rs_cause_pre", {26'd0, cause_3, cause_2, cause_1}, 32'b010101);
        cyc(3'b110, "rs_c1");
        rst = 1'b0;
        cyc(3'b000, "rs_held");
        check("rs_cause", {26'd0, cause_3, cause_2, cause_1}, 32'd0);
        check("rs_state", {29'd0, dbg_3, dbg_2, dbg_1}, 32'd0);
`ifdef HAZ_STALL_CNT_EN
        check("rs_stall_cycles", cyc_3, 32'd0);
`endif
        rst = 1'b1;
        cyc(3'b000, "rs_after");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised forwarding and hazard-detection unit for the 5-stage pipeline.
- Drives per-source EX-stage operand forwarding and ID-stage branch-compare forwarding, with independent priority per source.
- A counter-based stall FSM covers load-use and branch-in-ID hazards with configurable load latency.
- Sits beside the ID/EX pipeline registers; its stall output freezes PC and IF/ID and inserts a bubble into ID/EX.

Parameters:
- ADDR_W, 5, register-address width.
- NUM_SRC, 2, source operands per instruction (channel count).
- LOAD_LAT, 1, cycles after EX before load data is forwardable (>=1).
- CNT_W, $clog2(LOAD_LAT+2), stall counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- id_src  in  NUM_SRC*ADDR_W  ID-stage source regs; source i at [i*ADDR_W +: ADDR_W].
- id_src_vld  in  NUM_SRC  per-source "register is read" flag.
- id_is_branch  in  1  ID instruction compares registers in ID.
- ex_src  in  NUM_SRC*ADDR_W  EX-stage source regs.
- ex_rd, ex_regwrite, ex_memread  in  ADDR_W,1,1  EX-stage destination/controls.
- mem_rd, mem_regwrite, mem_memread  in  ADDR_W,1,1  EX/MEM destination/controls.
- wb_rd, wb_regwrite  in  ADDR_W,1  MEM/WB destination/control.
- mem_stall  in  1  memory busy; freezes stall counter.
- flush  in  1  taken branch/exception; aborts stall.
- fwd_ex  out  2*NUM_SRC  per-source EX mux select: 00 regfile, 01 EX/MEM, 10 MEM/WB.
- fwd_id  out  2*NUM_SRC  per-source ID compare select, same encoding.
- stall  out  1  hold PC and IF/ID, bubble ID/EX.
- stall_cause  out  2  registered: 00 none, 01 load-use, 10 branch-ALU, 11 branch-load.

Behaviour:
- "match(x,i)" means x != 0 and x == source i. Register 0 is never forwarded or stalled on.
- fwd_ex[i] (combinational):
  - 01 if mem_regwrite and match(mem_rd, ex_src i);
  - else 10 if wb_regwrite and match(wb_rd, ex_src i);
  - else 00.
  - Each source is evaluated independently; two sources may forward from different stages in the same cycle.
- fwd_id[i] (combinational): id_is_branch and id_src_vld[i] are required, otherwise 00.
  - 01 if mem_regwrite, !mem_memread and match(mem_rd);
  - else 10 if wb_regwrite and match(wb_rd).
- need (combinational, max over valid ID sources):
  - LOAD_LAT: ex_memread and match(ex_rd), non-branch (load-use).
  - 1: branch, ex_regwrite, !ex_memread, match(ex_rd).
  - LOAD_LAT+1: branch, ex_memread, match(ex_rd).
  - 1: branch, mem_memread, match(mem_rd).
  - Otherwise 0.
- FSM states IDLE, STALL; counter cnt[CNT_W].
  - IDLE: stall = (need>0). If need>=2, go to STALL with cnt<=need-1. stall_cause<=cause on any need>0, else 00.
  - STALL: stall=1. If cnt==1 go to IDLE, else cnt<=cnt-1.
  - Total stall cycles per hazard = need.
  - mem_stall=1: cnt and state hold; stall stays at its current value.
  - flush=1 (overrides all): stall=0 that cycle; next state IDLE, cnt=0, stall_cause=00.
- Reset (rst=0, asynchronous): state IDLE, cnt 0, stall_cause 00, counters 0. All outputs are forced 0 while reset is held. Reset mid-stall aborts the stall immediately.

Optional Feature:
- HAZ_STALL_CNT_EN defined:
  - Adds output stall_cycles [31:0].
  - Increments every cycle stall==1; saturates at 32'hFFFF_FFFF.
  - Cleared by reset only.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- mem_rd=8/mem_regwrite=1, wb_rd=8/wb_regwrite=1, ex_src0=8 -> fwd_ex[1:0]=01 (EX/MEM wins).
- ex_src0=3, ex_src1=4, mem_rd=3, wb_rd=4, both regwrite -> fwd_ex=4'b1001 in the same cycle. Repeating with mem_rd=0, ex_src0=0 -> fwd_ex[1:0]=00.
- LOAD_LAT=2; ex_memread=1, ex_rd=5, id_src0=5 valid, id_is_branch=0 -> stall high exactly 2 cycles, stall_cause=01, then low.
- LOAD_LAT=1; branch with ex_memread=1, ex_rd=7, id_src1=7 -> stall 2 cycles, cause=11. Repeat with flush=1 in the first stall cycle -> stall 0 that cycle, FSM IDLE.
- LOAD_LAT=3 load-use stall with mem_stall=1 for 2 cycles mid-stall -> stall asserted 5 cycles total. Repeat with rst=0 mid-stall -> stall 0 immediately, cause=00.
- HAZ_STALL_CNT_EN: 3 hazards of 1, 2 and 2 cycles -> stall_cycles=5.
